// File: rtl/snake_head_stepper_if.sv
// Handshake bundle between the direction/game-control side and the snake head stepper.
// The slave modport is the stepper's view; master is the controller or testbench view.
interface snake_head_stepper_if #(
  parameter int XW = 8,
  parameter int YW = 7
);
  logic          enable;
  logic          restart;
  logic [2:0]    dir_in;
  logic [XW-1:0] head_x;
  logic [YW-1:0] head_y;
  logic [2:0]    cur_dir;
  logic          step;
  logic          game_over;

  modport master (
    output enable, restart, dir_in,
    input  head_x, head_y, cur_dir, step, game_over
  );

  modport slave (
    input  enable, restart, dir_in,
    output head_x, head_y, cur_dir, step, game_over
  );
endinterface

// File: rtl/snake_head_stepper.sv
// Snake head stepper: divides clk into game ticks, advances the head, blocks reversals and
// detects wall hits. Define SNAKE_WRAP_AROUND_EN to make walls wrap instead of killing.
module snake_head_stepper #(
  parameter int XW       = 8,
  parameter int YW       = 7,
  parameter int X_MAX    = 159,
  parameter int Y_MAX    = 119,
  parameter int X_START  = 80,
  parameter int Y_START  = 60,
  parameter int TICK_DIV = 12500000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  snake_head_stepper_if.slave   bus_if
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
  localparam logic [XW-1:0] X_LAST   = XW'(X_MAX);
  localparam logic [YW-1:0] Y_LAST   = YW'(Y_MAX);
  localparam logic [XW-1:0] X_HOME   = XW'(X_START);
  localparam logic [YW-1:0] Y_HOME   = YW'(Y_START);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DEAD = 2'd2;

  // Direction code: [2]=1 vertical ([1]=0 up, 1 down); [2]=0 horizontal ([0]=0 left, 1 right)
  localparam logic [2:0] DIR_RESET = 3'b000;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [XW-1:0] x_q,     x_d;
  logic [YW-1:0] y_q,     y_d;
  logic [2:0]    dir_q,   dir_d;
  logic          step_q,  step_d;
  logic          over_q,  over_d;

  logic          tick;
  logic [2:0]    acc_dir;
  logic [XW-1:0] nx;
  logic [YW-1:0] ny;

  function automatic logic is_reversal(input logic [2:0] req, input logic [2:0] cur);
    logic same_axis;
    logic sense_diff;
    same_axis  = (req[2] == cur[2]);
    sense_diff = req[2] ? (req[1] != cur[1]) : (req[0] != cur[0]);
    return same_axis && sense_diff;
  endfunction

`ifndef SNAKE_WRAP_AROUND_EN
  function automatic logic hits_wall(input logic [2:0] d, input logic [XW-1:0] x,
                                     input logic [YW-1:0] y);
    logic hit;
    if (d[2]) hit = d[1] ? (y == Y_LAST) : (y == '0);
    else      hit = d[0] ? (x == X_LAST) : (x == '0);
    return hit;
  endfunction
`endif

  function automatic logic [XW-1:0] next_x(input logic [2:0] d, input logic [XW-1:0] x);
    logic [XW-1:0] r;
    r = x;
    if (!d[2]) begin
      if (d[0]) r = (x == X_LAST) ? '0 : x + XW'(1);
      else      r = (x == '0) ? X_LAST : x - XW'(1);
    end
    return r;
  endfunction

  function automatic logic [YW-1:0] next_y(input logic [2:0] d, input logic [YW-1:0] y);
    logic [YW-1:0] r;
    r = y;
    if (d[2]) begin
      if (d[1]) r = (y == Y_LAST) ? '0 : y + YW'(1);
      else      r = (y == '0) ? Y_LAST : y - YW'(1);
    end
    return r;
  endfunction

  // dir_in only reaches registers, and only through the tick-qualified move logic
  assign tick    = (state_q == ST_RUN) && bus_if.enable && (cnt_q == CNT_LAST);
  assign acc_dir = is_reversal(bus_if.dir_in, dir_q) ? dir_q : bus_if.dir_in;
  assign nx      = next_x(acc_dir, x_q);
  assign ny      = next_y(acc_dir, y_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    dir_d   = dir_q;
    step_d  = 1'b0;
    over_d  = over_q;

    if (bus_if.restart) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      x_d     = X_HOME;
      y_d     = Y_HOME;
      dir_d   = DIR_RESET;
      over_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_d = '0;
          if (bus_if.enable) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (tick) begin
            cnt_d = '0;
            dir_d = acc_dir;
`ifdef SNAKE_WRAP_AROUND_EN
            x_d    = nx;
            y_d    = ny;
            step_d = 1'b1;
`else
            if (hits_wall(acc_dir, x_q, y_q)) begin
              state_d = ST_DEAD;
              over_d  = 1'b1;
            end else begin
              x_d    = nx;
              y_d    = ny;
              step_d = 1'b1;
            end
`endif
          end else if (bus_if.enable) begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_DEAD: begin
          over_d = 1'b1;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      x_q     <= X_HOME;
      y_q     <= Y_HOME;
      dir_q   <= DIR_RESET;
      step_q  <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dir_q   <= dir_d;
      step_q  <= step_d;
      over_q  <= over_d;
    end
  end

  assign bus_if.head_x    = x_q;
  assign bus_if.head_y    = y_q;
  assign bus_if.cur_dir   = dir_q;
  assign bus_if.step      = step_q;
  assign bus_if.game_over = over_q;

endmodule

// File: tb/tb_snake_head_stepper.sv
// Randomized and directed bench for snake_head_stepper against a vector-based game model.
module tb_snake_head_stepper;

  localparam int XW = 8, YW = 7, XM = 159, YM = 119, XS = 80, YS = 60, TD = 4;

  logic clk = 1'b0;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;

  snake_head_stepper_if #(.XW(XW), .YW(YW)) bus ();

  snake_head_stepper #(
    .XW(XW), .YW(YW), .X_MAX(XM), .Y_MAX(YM),
    .X_START(XS), .Y_START(YS), .TICK_DIV(TD)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus_if(bus)
  );

  always #5 clk = ~clk;

  // Reference game: mode 0 idle, 1 running, 2 dead; phase counts enabled edges in running
  int         m_mode, m_phase, m_x, m_y, m_step, m_over;
  logic [2:0] m_dir;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void heading(input logic [2:0] c, output int dx, output int dy);
    if (c[2]) begin dx = 0; dy = c[1] ? 1 : -1; end
    else      begin dy = 0; dx = c[0] ? 1 : -1; end
  endfunction

  task automatic model_home();
    m_mode = 0; m_phase = 0; m_x = XS; m_y = YS; m_dir = 3'b000; m_step = 0; m_over = 0;
  endtask

  task automatic model_move(input logic [2:0] req);
    int cx, cy, rx, ry, tx, ty;
    logic [2:0] acc;
    heading(m_dir, cx, cy);
    heading(req, rx, ry);
    acc = (rx == -cx && ry == -cy) ? m_dir : req;
    heading(acc, tx, ty);
    tx = m_x + tx;
    ty = m_y + ty;
    m_dir = acc;
`ifdef SNAKE_WRAP_AROUND_EN
    m_x = (tx + XM + 1) % (XM + 1);
    m_y = (ty + YM + 1) % (YM + 1);
    m_step = 1;
`else
    if (tx < 0 || tx > XM || ty < 0 || ty > YM) begin
      m_mode = 2;
      m_over = 1;
    end else begin
      m_x = tx;
      m_y = ty;
      m_step = 1;
    end
`endif
  endtask

  task automatic model_edge();
    m_step = 0;
    if (bus.restart) model_home();
    else if (m_mode == 0) begin
      if (bus.enable) begin m_mode = 1; m_phase = 0; end
    end else if (m_mode == 1 && bus.enable) begin
      m_phase = (m_phase + 1) % TD;
      if (m_phase == 0) model_move(bus.dir_in);
    end
  endtask

  task automatic compare_all();
    check("head_x", int'(bus.head_x), m_x);
    check("head_y", int'(bus.head_y), m_y);
    check("cur_dir", int'(bus.cur_dir), int'(m_dir));
    check("step", int'(bus.step), m_step);
    check("game_over", int'(bus.game_over), m_over);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic wait_step(output int n, input int limit);
    n = 0;
    do begin
      cycle();
      n++;
    end while (!bus.step && n < limit);
    if (!bus.step) check("step_timeout", 0, 1);
  endtask

  initial begin
    int n, seg;
    reset_n = 1'b0;
    bus.enable = 1'b0; bus.restart = 1'b0; bus.dir_in = 3'b000;
    model_home();
    repeat (2) @(negedge clk);
    compare_all();
    check("rst_x", int'(bus.head_x), 80);
    check("rst_y", int'(bus.head_y), 60);
    check("rst_over", int'(bus.game_over), 0);
    reset_n = 1'b1;

    // Straight left from reset
    bus.enable = 1'b1;
    wait_step(n, 20); check("first_lat", n, 5); check("x1", int'(bus.head_x), 79);
    wait_step(n, 20); check("period", n, 4);    check("x2", int'(bus.head_x), 78);
    wait_step(n, 20); check("x3", int'(bus.head_x), 77); check("y3", int'(bus.head_y), 60);

    // Reversal blocked, then turn up
    bus.dir_in = 3'b001;
    wait_step(n, 20); check("rev_x", int'(bus.head_x), 76); check("rev_dir", int'(bus.cur_dir), 0);
    bus.dir_in = 3'b100;
    wait_step(n, 20); check("up_y", int'(bus.head_y), 59); check("up_dir", int'(bus.cur_dir), 4);

    // Run into the left wall
    bus.dir_in = 3'b000;
    for (int i = 0; i < 100 && bus.head_x != 0; i++) wait_step(n, 20);
    check("at_wall_x", int'(bus.head_x), 0);
    repeat (6) cycle();
`ifdef SNAKE_WRAP_AROUND_EN
    check("wrap_left_x", int'(bus.head_x) > 150 ? 1 : 0, 1);
    check("wrap_left_over", int'(bus.game_over), 0);
`else
    check("dead_over", int'(bus.game_over), 1);
    check("dead_x", int'(bus.head_x), 0);
    repeat (12) cycle();
    check("dead_hold_x", int'(bus.head_x), 0);
`endif

    // Restart back to idle, then the first step latency again
    bus.restart = 1'b1; cycle(); bus.restart = 1'b0;
    check("rs_x", int'(bus.head_x), 80); check("rs_y", int'(bus.head_y), 60);
    check("rs_dir", int'(bus.cur_dir), 0); check("rs_over", int'(bus.game_over), 0);
    wait_step(n, 20); check("rs_lat", n, 5); check("rs_x1", int'(bus.head_x), 79);

    // Pause mid-count
    cycle(); cycle();
    bus.enable = 1'b0;
    repeat (10) cycle();
    bus.enable = 1'b1;
    wait_step(n, 20); check("pause_lat", n, 2);

    // Restart landing on a tick edge wins over the move
    repeat (3) cycle();
    bus.restart = 1'b1; cycle(); bus.restart = 1'b0;
    check("rt_x", int'(bus.head_x), 80); check("rt_step", int'(bus.step), 0);

    // Up to the top wall
    bus.dir_in = 3'b100;
    for (int i = 0; i < 100 && bus.head_y != 0; i++) wait_step(n, 20);
    check("top_y", int'(bus.head_y), 0);
`ifdef SNAKE_WRAP_AROUND_EN
    wait_step(n, 20);
    check("wrap_y", int'(bus.head_y), 119); check("wrap_over", int'(bus.game_over), 0);
`else
    repeat (6) cycle();
    check("top_over", int'(bus.game_over), 1); check("top_hold_y", int'(bus.head_y), 0);
    check("top_dir", int'(bus.cur_dir), 4);
`endif

    // Randomized play
    bus.restart = 1'b1; cycle(); bus.restart = 1'b0;
    seg = 0;
    for (int i = 0; i < 20000; i++) begin
      if (seg == 0) begin
        bus.dir_in = 3'($urandom_range(0, 7));
        seg = $urandom_range(1, 300);
      end
      seg--;
      bus.enable  = ($urandom_range(0, 9) != 0);
      bus.restart = ($urandom_range(0, 599) == 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
